// File: rtl/instr_mem.sv
// Word-organised instruction ROM for the single-cycle fetch stage: zero-latency read,
// synchronous programming port and a sticky fetch-fault flag.
module instr_mem #(
  parameter int          DEPTH     = 1024,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  output logic [31:0] instruction,
  input  logic        prog_en,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data,
  output logic        misaligned,
  output logic        out_of_range,
  output logic        fault
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  logic [31:0] mem [0:DEPTH-1];

  logic [29:0] rd_idx;
  logic [29:0] wr_idx;
  logic        wr_in_range;
  logic        unused_ok;

  // Power-up image: NOP fill.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = NOP_WORD;
  end

  assign rd_idx       = address[31:2];
  assign wr_idx       = prog_addr[31:2];
  assign out_of_range = (rd_idx >= DEPTH_W);
  assign misaligned   = (address[1:0] != 2'b00);
  assign wr_in_range  = (wr_idx < DEPTH_W);
  assign unused_ok    = ^prog_addr[1:0];

  always_comb begin
    instruction = NOP_WORD;
    if (!out_of_range) instruction = mem[rd_idx[AW-1:0]];
  end

  // Writes share the reset domain so that a held reset also blocks programming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else begin
      fault <= fault | misaligned | out_of_range;
      if (prog_en && wr_in_range) mem[wr_idx[AW-1:0]] <= prog_data;
    end
  end

endmodule

// File: tb/tb_instr_mem.sv
// Bench for instr_mem: array-level reference model, per-cycle compare on the falling
// edge, directed boundary cases and randomized fetch/program traffic.
module tb_instr_mem;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] instruction;
  logic        prog_en;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        misaligned;
  logic        out_of_range;
  logic        fault;

  instr_mem #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .address      (address),
    .instruction  (instruction),
    .prog_en      (prog_en),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .misaligned   (misaligned),
    .out_of_range (out_of_range),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] model_mem [DEPTH];
  bit          model_fault;
  bit          cmp_en;
  int          n_cmp;
  int          n_bad;

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
    model_fault = 1'b0;
    cmp_en      = 1'b0;
    n_cmp       = 0;
    n_bad       = 0;
  end

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic logic [31:0] exp_instr(logic [31:0] a);
    if ((a >> 2) < DEPTH) return model_mem[a >> 2];
    return NOP;
  endfunction

  function automatic logic exp_oor(logic [31:0] a);
    return (a >> 2) >= DEPTH;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      if (prog_en && ((prog_addr >> 2) < DEPTH)) model_mem[prog_addr >> 2] = prog_data;
      model_fault = model_fault | (address % 4 != 0) | exp_oor(address);
    end
  end

  always @(negedge rst_n) model_fault = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_instruction", instruction, exp_instr(address));
      check("cyc_misaligned", {31'b0, misaligned}, {31'b0, (address % 4 != 0)});
      check("cyc_out_of_range", {31'b0, out_of_range}, {31'b0, exp_oor(address)});
      check("cyc_fault", {31'b0, fault}, {31'b0, model_fault});
    end
  end

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_en = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_en = 1'b0;
  endtask

  task automatic step_addr(input logic [31:0] a);
    address = a;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("async_reset_fault", {31'b0, fault}, 32'd0);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 32'($urandom_range(0, DEPTH - 1)) << 2;
    if (r == 7) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
    if (r == 8) return $urandom;
    return (r == 9 && $urandom_range(0, 1) == 1) ? 32'(DEPTH * 4) : 32'(DEPTH * 4 - 4);
  endfunction

  logic [31:0] prog_words [4];

  initial begin
    prog_words[0] = 32'h0050_0093;
    prog_words[1] = 32'h00A0_0113;
    prog_words[2] = 32'h0020_81B3;
    prog_words[3] = 32'h0000_0013;

    rst_n = 1'b1; address = '0; prog_en = 1'b0; prog_addr = '0; prog_data = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_fault", {31'b0, fault}, 32'd0);
    check("reset_nop_fill", instruction, NOP);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    for (int i = 0; i < 3; i++) prog(32'(i * 4), prog_words[i]);

    for (int i = 0; i < 4; i++) begin
      address = 32'(i * 4);
      #1;
      check("preload_word", instruction, prog_words[i]);
      @(posedge clk); #1;
    end
    check("preload_fault", {31'b0, fault}, 32'd0);

    for (int i = 0; i <= 39; i++) begin
      address = 32'(i * 4);
      #1;
      if (i >= 3) check("sweep_nop", instruction, NOP);
      @(posedge clk); #1;
    end

    prog(32'(DEPTH * 4 - 4), 32'hCAFE_0001);

    address = 32'h6;
    #1;
    check("misaligned_data", instruction, 32'h00A0_0113);
    check("misaligned_flag", {31'b0, misaligned}, 32'd1);
    @(posedge clk); #1;
    check("misaligned_fault", {31'b0, fault}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midcycle_reset_fault", {31'b0, fault}, 32'd0);
    @(posedge clk); #1;
    check("fault_held_in_reset", {31'b0, fault}, 32'd0);
    rst_n = 1'b1; address = 32'h0;
    @(posedge clk); #1;

    address = 32'(DEPTH * 4);
    #1;
    check("past_end_data", instruction, NOP);
    check("past_end_oor", {31'b0, out_of_range}, 32'd1);
    address = 32'(DEPTH * 4 - 4);
    #1;
    check("last_word_data", instruction, 32'hCAFE_0001);
    check("last_word_oor", {31'b0, out_of_range}, 32'd0);
    address = 32'hFFFF_FFFC;
    #1;
    check("high_addr_data", instruction, NOP);
    check("high_addr_oor", {31'b0, out_of_range}, 32'd1);
    step_addr(32'hFFFF_FFFC);
    check("oor_fault", {31'b0, fault}, 32'd1);
    pulse_reset();
    address = 32'h8;
    @(posedge clk); #1;

    prog_en = 1'b1; prog_addr = 32'h8; prog_data = 32'hDEAD_BEEF;
    #1;
    check("rdw_before_edge", instruction, 32'h0020_81B3);
    @(posedge clk); #1;
    prog_en = 1'b0;
    check("rdw_after_edge", instruction, 32'hDEAD_BEEF);

    rst_n = 1'b0;
    prog_en = 1'b1; prog_addr = 32'h8; prog_data = 32'h1234_5678;
    @(posedge clk); #1;
    check("write_in_reset", instruction, 32'hDEAD_BEEF);
    prog_en = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    prog(32'h0001_0000, 32'h0BAD_0BAD);
    address = 32'h0;
    #1;
    check("oor_write_word0", instruction, 32'h0050_0093);
    for (int i = 0; i < DEPTH; i++) begin
      address = 32'(i * 4);
      #1;
      check("oor_write_scan", instruction, model_mem[i]);
    end
    @(posedge clk); #1;

    for (int n = 0; n < 600; n++) begin
      address = rand_addr();
      prog_en = ($urandom_range(0, 2) == 0);
      prog_addr = rand_addr();
      prog_data = $urandom;
      #1;
      check("rand_instruction", instruction, exp_instr(address));
      if ($urandom_range(0, 39) == 0) pulse_reset();
      @(posedge clk); #1;
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
